// File: rtl/watch_time_counter.sv
// Real-time-clock core: holds date and time of day, advances one second per
// tick_1s with full calendar carry (leap years included) and accepts clamped loads.
module watch_time_counter #(
    parameter int unsigned RST_YEAR  = 0,
    parameter int unsigned RST_MONTH = 1,
    parameter int unsigned RST_DAY   = 1,
    parameter int unsigned RST_HOUR  = 0,
    parameter int unsigned YEAR_MAX  = 99
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_1s,
    input  logic        hold,
    input  logic        en_time,
    input  logic [47:0] bin_time,
    output logic [7:0]  year,
    output logic [7:0]  month,
    output logic [7:0]  day,
    output logic [7:0]  hour,
    output logic [7:0]  minute,
    output logic [7:0]  second,
    output logic        day_tick
);

    localparam logic [7:0] YEAR_MAX_B  = 8'(YEAR_MAX);
    localparam logic [7:0] RST_YEAR_B  = 8'(RST_YEAR);
    localparam logic [7:0] RST_MONTH_B = 8'(RST_MONTH);
    localparam logic [7:0] RST_DAY_B   = 8'(RST_DAY);
    localparam logic [7:0] RST_HOUR_B  = 8'(RST_HOUR);

    logic [7:0] year_q,   year_d;
    logic [7:0] month_q,  month_d;
    logic [7:0] day_q,    day_d;
    logic [7:0] hour_q,   hour_d;
    logic [7:0] minute_q, minute_d;
    logic [7:0] second_q, second_d;
    logic       day_tick_q, day_tick_d;

    logic [7:0] ld_year, ld_month, ld_day, ld_hour, ld_minute, ld_second;
    logic [7:0] ld_dim, cur_dim;

    // Every year offset divisible by four is a leap year, since offset 0 is 2000.
    function automatic logic [7:0] days_in_month(input logic [7:0] m, input logic [1:0] y_lo);
        logic [7:0] d;
        case (m)
            8'd4, 8'd6, 8'd9, 8'd11: d = 8'd30;
            8'd2:                    d = (y_lo == 2'd0) ? 8'd29 : 8'd28;
            default:                 d = 8'd31;
        endcase
        return d;
    endfunction

    always_comb begin
        ld_second = (bin_time[7:0]   > 8'd59) ? 8'd59 : bin_time[7:0];
        ld_minute = (bin_time[15:8]  > 8'd59) ? 8'd59 : bin_time[15:8];
        ld_hour   = (bin_time[23:16] > 8'd23) ? 8'd23 : bin_time[23:16];
        ld_year   = (bin_time[47:40] > YEAR_MAX_B) ? YEAR_MAX_B : bin_time[47:40];
        if (bin_time[39:32] == 8'd0) begin
            ld_month = 8'd1;
        end else if (bin_time[39:32] > 8'd12) begin
            ld_month = 8'd12;
        end else begin
            ld_month = bin_time[39:32];
        end
        ld_dim = days_in_month(ld_month, ld_year[1:0]);
        if (bin_time[31:24] == 8'd0) begin
            ld_day = 8'd1;
        end else if (bin_time[31:24] > ld_dim) begin
            ld_day = ld_dim;
        end else begin
            ld_day = bin_time[31:24];
        end
    end

    // The whole carry chain resolves in one cycle so all fields change together.
    always_comb begin
        year_d     = year_q;
        month_d    = month_q;
        day_d      = day_q;
        hour_d     = hour_q;
        minute_d   = minute_q;
        second_d   = second_q;
        day_tick_d = 1'b0;
        cur_dim    = days_in_month(month_q, year_q[1:0]);
        if (en_time) begin
            year_d   = ld_year;
            month_d  = ld_month;
            day_d    = ld_day;
            hour_d   = ld_hour;
            minute_d = ld_minute;
            second_d = ld_second;
        end else if (tick_1s && !hold) begin
            if (second_q >= 8'd59) begin
                second_d = 8'd0;
                if (minute_q >= 8'd59) begin
                    minute_d = 8'd0;
                    if (hour_q >= 8'd23) begin
                        hour_d     = 8'd0;
                        day_tick_d = 1'b1;
                        if (day_q >= cur_dim) begin
                            day_d = 8'd1;
                            if (month_q >= 8'd12) begin
                                month_d = 8'd1;
                                year_d  = (year_q >= YEAR_MAX_B) ? 8'd0 : year_q + 8'd1;
                            end else begin
                                month_d = month_q + 8'd1;
                            end
                        end else begin
                            day_d = day_q + 8'd1;
                        end
                    end else begin
                        hour_d = hour_q + 8'd1;
                    end
                end else begin
                    minute_d = minute_q + 8'd1;
                end
            end else begin
                second_d = second_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            year_q     <= RST_YEAR_B;
            month_q    <= RST_MONTH_B;
            day_q      <= RST_DAY_B;
            hour_q     <= RST_HOUR_B;
            minute_q   <= 8'd0;
            second_q   <= 8'd0;
            day_tick_q <= 1'b0;
        end else begin
            year_q     <= year_d;
            month_q    <= month_d;
            day_q      <= day_d;
            hour_q     <= hour_d;
            minute_q   <= minute_d;
            second_q   <= second_d;
            day_tick_q <= day_tick_d;
        end
    end

    assign year     = year_q;
    assign month    = month_q;
    assign day      = day_q;
    assign hour     = hour_q;
    assign minute   = minute_q;
    assign second   = second_q;
    assign day_tick = day_tick_q;

endmodule

// File: tb/tb_watch_time_counter.sv
// Directed bench for watch_time_counter: a vector table of single-cycle events
// followed by a few multi-cycle sequences with hand-computed results.
module tb_watch_time_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick_1s = 1'b0;
    logic        hold = 1'b0;
    logic        en_time = 1'b0;
    logic [47:0] bin_time = '0;
    logic [7:0]  year, month, day, hour, minute, second;
    logic        day_tick;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic        rst_n;
        logic        en;
        logic        tick;
        logic        hold;
        logic [47:0] bt;
        logic [47:0] exp_time;
        logic        exp_dt;
    } vec_t;

    vec_t vecs[$];

    watch_time_counter dut (
        .clk(clk), .rst(rst), .tick_1s(tick_1s), .hold(hold), .en_time(en_time),
        .bin_time(bin_time), .year(year), .month(month), .day(day), .hour(hour),
        .minute(minute), .second(second), .day_tick(day_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [47:0] t(input int y, input int mo, input int d,
                                      input int h, input int mi, input int s);
        return {8'(y), 8'(mo), 8'(d), 8'(h), 8'(mi), 8'(s)};
    endfunction

    task automatic addVec(input string name, input logic rst_n, input logic en, input logic tick,
                          input logic hld, input logic [47:0] bt, input logic [47:0] exp_time,
                          input logic exp_dt);
        vec_t v;
        v.name = name; v.rst_n = rst_n; v.en = en; v.tick = tick; v.hold = hld;
        v.bt = bt; v.exp_time = exp_time; v.exp_dt = exp_dt;
        vecs.push_back(v);
    endtask

    // Called on a falling edge: drive inputs, let one rising edge pass, return on the next falling edge.
    task automatic applyStimulus(input logic rst_n, input logic en, input logic tick,
                                 input logic hld, input logic [47:0] bt);
        rst = rst_n; en_time = en; tick_1s = tick; hold = hld; bin_time = bt;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [47:0] exp_time, input logic exp_dt);
        logic [47:0] act;
        act = {year, month, day, hour, minute, second};
        checks++;
        if (act !== exp_time || day_tick !== exp_dt) begin
            failures++;
            $display("[TB] FAIL %s: got y/mo/d/h/mi/s=%0d/%0d/%0d %0d:%0d:%0d day_tick=%b, expected %0d/%0d/%0d %0d:%0d:%0d day_tick=%b",
                     name, act[47:40], act[39:32], act[31:24], act[23:16], act[15:8], act[7:0], day_tick,
                     exp_time[47:40], exp_time[39:32], exp_time[31:24], exp_time[23:16],
                     exp_time[15:8], exp_time[7:0], exp_dt);
        end
    endtask

    initial begin
        logic [47:0] rst_t;
        int dt_count;
        rst_t = t(0, 1, 1, 0, 0, 0);

        addVec("rst_a",         0, 0, 0, 0, '0,                    rst_t,                  0);
        addVec("rst_b",         0, 0, 0, 0, '0,                    rst_t,                  0);
        addVec("idle",          1, 0, 0, 0, '0,                    rst_t,                  0);
        addVec("tick1",         1, 0, 1, 0, '0,                    t(0, 1, 1, 0, 0, 1),    0);
        addVec("load_ywrap",    1, 1, 0, 0, t(99, 12, 31, 23, 59, 59), t(99, 12, 31, 23, 59, 59), 0);
        addVec("ywrap",         1, 0, 1, 0, '0,                    rst_t,                  1);
        addVec("dt_drop",       1, 0, 0, 0, '0,                    rst_t,                  0);
        addVec("load_leap",     1, 1, 0, 0, t(24, 2, 28, 23, 59, 59), t(24, 2, 28, 23, 59, 59), 0);
        addVec("leap_feb29",    1, 0, 1, 0, '0,                    t(24, 2, 29, 0, 0, 0),  1);
        addVec("load_feb29",    1, 1, 0, 0, t(24, 2, 29, 23, 59, 59), t(24, 2, 29, 23, 59, 59), 0);
        addVec("leap_mar1",     1, 0, 1, 0, '0,                    t(24, 3, 1, 0, 0, 0),   1);
        addVec("load_nonleap",  1, 1, 0, 0, t(23, 2, 28, 23, 59, 59), t(23, 2, 28, 23, 59, 59), 0);
        addVec("nonleap_mar1",  1, 0, 1, 0, '0,                    t(23, 3, 1, 0, 0, 0),   1);
        addVec("clamp_all",     1, 1, 0, 0, t(200, 0, 45, 30, 75, 99), t(99, 1, 31, 23, 59, 59), 0);
        addVec("clamp_apr31",   1, 1, 0, 0, t(23, 4, 31, 10, 0, 0),  t(23, 4, 30, 10, 0, 0), 0);
        addVec("clamp_feb_lp",  1, 1, 0, 0, t(4, 2, 30, 0, 0, 0),    t(4, 2, 29, 0, 0, 0),   0);
        addVec("clamp_feb_nl",  1, 1, 0, 0, t(3, 2, 31, 0, 0, 0),    t(3, 2, 28, 0, 0, 0),   0);
        addVec("clamp_day0",    1, 1, 0, 0, t(3, 5, 0, 0, 0, 0),     t(3, 5, 1, 0, 0, 0),    0);
        addVec("load_vs_tick",  1, 1, 1, 0, t(10, 6, 15, 12, 0, 0),  t(10, 6, 15, 12, 0, 0), 0);
        addVec("rst_vs_load",   0, 1, 0, 0, t(50, 5, 5, 5, 5, 5),    rst_t,                  0);
        addVec("hold_tick_a",   1, 0, 1, 1, '0,                    rst_t,                  0);
        addVec("hold_tick_b",   1, 0, 1, 1, '0,                    rst_t,                  0);
        addVec("hold_load",     1, 1, 0, 1, t(5, 7, 4, 9, 30, 15),   t(5, 7, 4, 9, 30, 15),  0);
        addVec("unhold_tick",   1, 0, 1, 0, '0,                    t(5, 7, 4, 9, 30, 16),  0);
        addVec("load_mcarry",   1, 1, 0, 0, t(5, 7, 4, 9, 30, 59),   t(5, 7, 4, 9, 30, 59),  0);
        addVec("min_carry",     1, 0, 1, 0, '0,                    t(5, 7, 4, 9, 31, 0),   0);
        addVec("load_hcarry",   1, 1, 0, 0, t(5, 7, 4, 9, 59, 59),   t(5, 7, 4, 9, 59, 59),  0);
        addVec("hour_carry",    1, 0, 1, 0, '0,                    t(5, 7, 4, 10, 0, 0),   0);
        addVec("load_day_mid",  1, 1, 0, 0, t(5, 7, 4, 23, 59, 59),  t(5, 7, 4, 23, 59, 59), 0);
        addVec("day_carry",     1, 0, 1, 0, '0,                    t(5, 7, 5, 0, 0, 0),    1);
        addVec("load_apr30",    1, 1, 0, 0, t(4, 4, 30, 23, 59, 59), t(4, 4, 30, 23, 59, 59), 0);
        addVec("apr_to_may",    1, 0, 1, 0, '0,                    t(4, 5, 1, 0, 0, 0),    1);
        addVec("load_rollrst",  1, 1, 0, 0, t(99, 12, 31, 23, 59, 59), t(99, 12, 31, 23, 59, 59), 0);
        addVec("rst_vs_tick",   0, 0, 1, 0, '0,                    rst_t,                  0);
        addVec("post_rst_idle", 1, 0, 0, 0, '0,                    rst_t,                  0);

        @(negedge clk);
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst_n, vecs[i].en, vecs[i].tick, vecs[i].hold, vecs[i].bt);
            checkOutput(vecs[i].name, vecs[i].exp_time, vecs[i].exp_dt);
        end

        // Two reset cycles, then ten consecutive ticks.
        applyStimulus(0, 0, 0, 0, '0);
        applyStimulus(0, 0, 0, 0, '0);
        checkOutput("seq_reset", rst_t, 0);
        for (int i = 0; i < 10; i++) applyStimulus(1, 0, 1, 0, '0);
        applyStimulus(1, 0, 0, 0, '0);
        checkOutput("seq_ten_ticks", t(0, 1, 1, 0, 0, 10), 0);

        // 600 seconds from 23:50:00 on Feb 29 of a leap year lands on Mar 1 midnight.
        applyStimulus(1, 1, 0, 0, t(24, 2, 29, 23, 50, 0));
        checkOutput("seq_leap_load", t(24, 2, 29, 23, 50, 0), 0);
        dt_count = 0;
        for (int i = 0; i < 600; i++) begin
            applyStimulus(1, 0, 1, 0, '0);
            if (day_tick === 1'b1) dt_count++;
        end
        checkOutput("seq_leap_600s", t(24, 3, 1, 0, 0, 0), 1);
        applyStimulus(1, 0, 0, 0, '0);
        checkOutput("seq_leap_idle", t(24, 3, 1, 0, 0, 0), 0);
        checks++;
        if (dt_count != 1) begin
            failures++;
            $display("[TB] FAIL seq_day_tick_count: got %0d pulses, expected 1", dt_count);
        end

        // Five held ticks leave the time frozen.
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 1, 1, '0);
        checkOutput("seq_hold5", t(24, 3, 1, 0, 0, 0), 0);
        applyStimulus(1, 0, 1, 0, '0);
        checkOutput("seq_hold_release", t(24, 3, 1, 0, 0, 1), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/watch_time_counter.md
Name: watch_time_counter

Overview:
- Running real-time-clock core that sits directly upstream and downstream of the watch set mode.
- Keeps the current calendar date and time of day, and advances it by one second on each 1 Hz tick, including calendar rollover and leap years.
- Drives the year, month, day, hour, minute and second values that the display and set-mode blocks read.
- Loads a new date and time when set mode issues its packed bin_time word with the en_time strobe.

Parameters:
- RST_YEAR, 0, year at reset, as years since 2000 (0..YEAR_MAX)
- RST_MONTH, 1, month at reset (1..12)
- RST_DAY, 1, day at reset (1..days in RST_MONTH)
- RST_HOUR, 0, hour at reset (0..23)
- YEAR_MAX, 99, last valid year offset; the year after it wraps to 0

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-low reset, sampled on the rising edge of clk
- tick_1s  input  1  one-clk-cycle pulse, once per second, synchronous to clk
- hold  input  1  when 1, tick_1s is ignored and the time is frozen
- en_time  input  1  one-cycle load strobe from set mode
- bin_time  input  48  load word: [7:0] sec, [15:8] min, [23:16] hour, [31:24] day, [39:32] month, [47:40] year
- year, month, day, hour, minute, second  output  8 each  current binary values, all registered
- day_tick  output  1  one-cycle pulse when the day rolls over from 23:59:59

Behaviour:
- Clocking and reset:
  - Single clock domain; all state updates on the rising edge of clk.
  - rst=0 at an edge: year=RST_YEAR, month=RST_MONTH, day=RST_DAY, hour=RST_HOUR, minute=0, second=0, day_tick=0.
  - Reset overrides load and tick in the same cycle. Reset asserted mid-rollover leaves no partial carry.
- Priority in each cycle: reset > load (en_time=1) > tick (tick_1s=1 and hold=0) > idle (values held).
- Latency: one cycle. An event sampled at edge N is visible on the outputs after edge N. All six fields update atomically in that same edge; no ripple across cycles.
- Load:
  - Each field of bin_time is clamped to its legal range in the load cycle.
  - second > 59 becomes 59; minute > 59 becomes 59; hour > 23 becomes 23.
  - month 0 becomes 1; month > 12 becomes 12.
  - year > YEAR_MAX becomes YEAR_MAX.
  - day 0 becomes 1; day > dim(clamped month, clamped year) becomes dim.
  - A tick that coincides with a load is dropped, not deferred.
  - day_tick=0 in a load cycle.
- Tick carry chain:
  - second+1. If second was 59: second=0 and minute+1.
  - If minute was also 59: minute=0 and hour+1.
  - If hour was also 23: hour=0, day+1, and day_tick=1 for that cycle only.
  - If day was also dim: day=1 and month+1.
  - If month was also 12: month=1 and year+1.
  - If year was also YEAR_MAX: year=0.
- Days in month (dim):
  - 31 for months 1, 3, 5, 7, 8, 10, 12.
  - 30 for months 4, 6, 9, 11.
  - February is 29 when year[1:0]==0, otherwise 28. Offset 0 is year 2000, which is a leap year.
- hold=1 suppresses ticks only. A load is still accepted while hold=1.
- day_tick is 0 in every cycle except a midnight rollover cycle.
- Outputs never leave their legal ranges, from any sequence of inputs.
- Arithmetic is 8-bit unsigned. Carries are computed combinationally from the current registers.

Test Plan:
- Reset: rst=0 for 2 cycles, then 1 -> outputs 0/1/1 0:00:00, day_tick=0. Ten ticks -> second=10, all other fields unchanged.
- Year wrap: load {99,12,31,23,59,59}, then one tick -> next cycle shows year=0, month=1, day=1, 00:00:00, and day_tick=1 for exactly one cycle.
- Leap years:
  - Load {24,2,28,23,59,59}, then tick -> day=29, month=2.
  - Tick again through 86400 s -> day=1, month=3.
  - Load {23,2,28,23,59,59}, then tick -> day=1, month=3.
- Load clamping:
  - bin_time {200,0,45,30,75,99} -> year=99, month=1, day=31, hour=23, minute=59, second=59.
  - bin_time {23,4,31,10,0,0} -> day=30.
- Simultaneous events: en_time=1 and tick_1s=1 in the same cycle with load {10,6,15,12,0,0} -> outputs exactly 12:00:00 (tick dropped). rst=0 together with en_time=1 -> reset values.
- Hold: hold=1 with 5 ticks -> time unchanged. A load during hold -> accepted. hold=0 with 1 tick -> second increments by 1.
